// File: rtl/dual_issue_queue.sv
// dual_issue_queue: in-order dual-issue dispatch stage.
// A DEPTH-entry circular queue sits between decode and two issue pipes.
// The head goes to the full-function pipe1, and the next entry may pair
// onto the arithmetic-only pipe0. A per-register down-counter scoreboard
// blocks readers of multi-cycle results for MC_LAT issue decisions.
// r0 is never a hazard.
// Optional feature: define DISPATCH_SWAP_EN to allow swapped pairing, where
// the head goes to pipe0 and the next entry goes to pipe1 (out_swap_o = 1).
module dual_issue_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PAYLOAD_W = 256,
    parameter int unsigned MC_LAT    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 stall_i,
    // Enqueue side; slot 0 is the older instruction
    input  logic                 in_valid0_i,
    input  logic                 in_valid1_i,
    output logic                 in_ready_o,
    input  logic [4:0]           in_rd0_i,
    input  logic [4:0]           in_rj0_i,
    input  logic [4:0]           in_rk0_i,
    input  logic [3:0]           in_type0_i,
    input  logic                 in_regwrite0_i,
    input  logic                 in_rdsrc0_i,
    input  logic [PAYLOAD_W-1:0] in_payload0_i,
    input  logic [4:0]           in_rd1_i,
    input  logic [4:0]           in_rj1_i,
    input  logic [4:0]           in_rk1_i,
    input  logic [3:0]           in_type1_i,
    input  logic                 in_regwrite1_i,
    input  logic                 in_rdsrc1_i,
    input  logic [PAYLOAD_W-1:0] in_payload1_i,
    // Pipe0 (arithmetic-only) issue registers
    output logic                 out_valid0_o,
    output logic [4:0]           out_rd0_o,
    output logic [4:0]           out_rj0_o,
    output logic [4:0]           out_rk0_o,
    output logic [3:0]           out_type0_o,
    output logic                 out_regwrite0_o,
    output logic [PAYLOAD_W-1:0] out_payload0_o,
    // Pipe1 (full-function) issue registers
    output logic                 out_valid1_o,
    output logic [4:0]           out_rd1_o,
    output logic [4:0]           out_rj1_o,
    output logic [4:0]           out_rk1_o,
    output logic [3:0]           out_type1_o,
    output logic                 out_regwrite1_o,
    output logic [PAYLOAD_W-1:0] out_payload1_o,
    output logic                 out_swap_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    // Issued bundle: {rd, rj, rk, type, regwrite, payload}
    localparam int unsigned OW = PAYLOAD_W + 20;
    // Stored entry: {rd, rj, rk, type, regwrite, rdsrc, payload}
    localparam int unsigned EW = PAYLOAD_W + 21;
    localparam logic [2:0]  McLoad = 3'(MC_LAT);

    // Arithmetic-only pipe0 accepts alu, br, mul, rdcnt, alu+br and ibar
    function automatic logic is_pipe0(input logic [3:0] t);
        case (t)
            4'd0, 4'd1, 4'd4, 4'd7, 4'd8, 4'd9: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // div, priv, mul and dcache produce their result after several cycles
    function automatic logic is_mc_type(input logic [3:0] t);
        case (t)
            4'd2, 4'd3, 4'd4, 4'd5: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

`ifdef DISPATCH_SWAP_EN
    function automatic logic is_priv(input logic [3:0] t);
        case (t)
            4'd3, 4'd6, 4'd10: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction
`endif

    // ---------------------------------------------------------------
    // Queue storage and pointers
    // ---------------------------------------------------------------
    logic [EW-1:0] ent_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW-1:0] occ;
    logic [AW-1:0] h_idx, n_idx, w0_idx, w1_idx;
    logic          empty, has_next;
    logic          do_enq, wr0_en, wr1_en;
    logic [EW-1:0] slot0_ent, slot1_ent, wr0_ent;

    assign occ        = wptr_q - rptr_q;
    assign empty      = (occ == '0);
    assign has_next   = (occ >= PW'(2));
    // Two free entries are always required, even for a single enqueue
    assign in_ready_o = (occ <= PW'(DEPTH - 2));

    assign h_idx  = rptr_q[AW-1:0];
    assign n_idx  = h_idx + AW'(1);
    assign w0_idx = wptr_q[AW-1:0];
    assign w1_idx = w0_idx + AW'(1);

    assign slot0_ent = {in_rd0_i, in_rj0_i, in_rk0_i, in_type0_i,
                        in_regwrite0_i, in_rdsrc0_i, in_payload0_i};
    assign slot1_ent = {in_rd1_i, in_rj1_i, in_rk1_i, in_type1_i,
                        in_regwrite1_i, in_rdsrc1_i, in_payload1_i};

    // A lone slot-1 request is compacted into the first free entry
    assign do_enq  = in_ready_o && !flush_i;
    assign wr0_en  = do_enq && (in_valid0_i || in_valid1_i);
    assign wr1_en  = do_enq && in_valid0_i && in_valid1_i;
    assign wr0_ent = in_valid0_i ? slot0_ent : slot1_ent;

    // Entry storage; contents are only meaningful between the pointers
    always_ff @(posedge clk_i) begin
        if (wr0_en) ent_q[w0_idx] <= wr0_ent;
        if (wr1_en) ent_q[w1_idx] <= slot1_ent;
    end

    // ---------------------------------------------------------------
    // Head / next decode
    // ---------------------------------------------------------------
    logic [EW-1:0] h_ent, n_ent;
    logic [4:0]    h_rd, h_rj, h_rk, n_rd, n_rj, n_rk;
    logic [3:0]    h_type, n_type;
    logic          h_rw, h_rdsrc, n_rw, n_rdsrc;
    logic [OW-1:0] h_out, n_out;

    assign h_ent = ent_q[h_idx];
    assign n_ent = ent_q[n_idx];
    assign {h_rd, h_rj, h_rk, h_type, h_rw, h_rdsrc} = h_ent[EW-1:PAYLOAD_W];
    assign {n_rd, n_rj, n_rk, n_type, n_rw, n_rdsrc} = n_ent[EW-1:PAYLOAD_W];
    // rdsrc is a hazard-only field and is not forwarded to the pipes
    assign h_out = {h_ent[EW-1:PAYLOAD_W+1], h_ent[PAYLOAD_W-1:0]};
    assign n_out = {n_ent[EW-1:PAYLOAD_W+1], n_ent[PAYLOAD_W-1:0]};

    // ---------------------------------------------------------------
    // Scoreboard and issue decision
    // ---------------------------------------------------------------
    logic [2:0]  cnt_q [32];
    logic [2:0]  cnt_d [32];
    logic [31:0] reg_busy;
    logic        h_src_busy, n_src_busy, n_reads_hrd, waw, pair_dep_ok;
    logic        iss_h, iss_pair, iss_swap, iss_n;
    logic        ld_h, ld_n;

    // count[0] is never loaded, so r0 can never appear busy
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            reg_busy[r] = (cnt_q[r] != 3'd0);
        end
    end

    assign h_src_busy = reg_busy[h_rj] | reg_busy[h_rk] | (h_rdsrc & reg_busy[h_rd]);
    assign n_src_busy = reg_busy[n_rj] | reg_busy[n_rk] | (n_rdsrc & reg_busy[n_rd]);

    assign n_reads_hrd = h_rw && (h_rd != 5'd0) &&
                         ((n_rj == h_rd) || (n_rk == h_rd) || (n_rdsrc && (n_rd == h_rd)));
    assign waw         = h_rw && n_rw && (h_rd == n_rd) && (h_rd != 5'd0);
    assign pair_dep_ok = !n_src_busy && !n_reads_hrd && !waw;

    assign iss_h    = !empty && !h_src_busy;
    assign iss_pair = iss_h && has_next && is_pipe0(n_type) && pair_dep_ok;
`ifdef DISPATCH_SWAP_EN
    assign iss_swap = iss_h && has_next && is_pipe0(h_type) && !is_pipe0(n_type) &&
                      !is_priv(n_type) && pair_dep_ok;
`else
    assign iss_swap = 1'b0;
`endif
    assign iss_n = iss_pair || iss_swap;

    assign ld_h = iss_h && is_mc_type(h_type) && h_rw && (h_rd != 5'd0);
    assign ld_n = iss_n && is_mc_type(n_type) && n_rw && (n_rd != 5'd0);

    // Pointer next state: flush drops the queue and any in-flight enqueue
    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        if (flush_i) begin
            rptr_d = wptr_q;
        end else begin
            if (!stall_i) rptr_d = rptr_q + PW'(iss_h) + PW'(iss_n);
            if (do_enq)   wptr_d = wptr_q + PW'(in_valid0_i) + PW'(in_valid1_i);
        end
    end

    // Pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Scoreboard next state: decrement live counts, loads win over decrement
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        if (flush_i) begin
            for (int r = 0; r < 32; r++) begin
                cnt_d[r] = 3'd0;
            end
        end else if (!stall_i) begin
            for (int r = 0; r < 32; r++) begin
                if (cnt_q[r] != 3'd0) cnt_d[r] = cnt_q[r] - 3'd1;
            end
            if (ld_h) cnt_d[h_rd] = McLoad;
            if (ld_n) cnt_d[n_rd] = McLoad;
        end
    end

    // Scoreboard registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= 3'd0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // ---------------------------------------------------------------
    // Issue registers
    // ---------------------------------------------------------------
    logic          out_valid0_q, out_valid0_d, out_valid1_q, out_valid1_d;
    logic          out_swap_q, out_swap_d;
    logic [OW-1:0] out0_q, out0_d, out1_q, out1_d;

    // Route head/next to the pipes; idle pipes carry all-zero bundles
    always_comb begin
        out_valid1_d = iss_h;
        out_valid0_d = iss_n;
        out_swap_d   = iss_swap;
        out0_d       = '0;
        out1_d       = '0;
        if (iss_swap) begin
            out1_d = n_out;
            out0_d = h_out;
        end else begin
            if (iss_h)    out1_d = h_out;
            if (iss_pair) out0_d = n_out;
        end
    end

    // Output registers: flush clears, stall holds
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid0_q <= 1'b0;
            out_valid1_q <= 1'b0;
            out_swap_q   <= 1'b0;
            out0_q       <= '0;
            out1_q       <= '0;
        end else if (flush_i) begin
            out_valid0_q <= 1'b0;
            out_valid1_q <= 1'b0;
            out_swap_q   <= 1'b0;
            out0_q       <= '0;
            out1_q       <= '0;
        end else if (!stall_i) begin
            out_valid0_q <= out_valid0_d;
            out_valid1_q <= out_valid1_d;
            out_swap_q   <= out_swap_d;
            out0_q       <= out0_d;
            out1_q       <= out1_d;
        end
    end

    assign out_valid0_o = out_valid0_q;
    assign out_valid1_o = out_valid1_q;
    assign out_swap_o   = out_swap_q;
    assign {out_rd0_o, out_rj0_o, out_rk0_o, out_type0_o, out_regwrite0_o, out_payload0_o} = out0_q;
    assign {out_rd1_o, out_rj1_o, out_rk1_o, out_type1_o, out_regwrite1_o, out_payload1_o} = out1_q;

endmodule

// File: tb/tb_dual_issue_queue.sv
// tb_dual_issue_queue: directed stimulus against an in-bench queue model.
`timescale 1ns/1ps
module tb_dual_issue_queue;

    localparam int DEPTH = 8;
    localparam int MCL   = 3;
    localparam int CW    = 300;

    typedef struct packed {
        logic [4:0]   rd;
        logic [4:0]   rj;
        logic [4:0]   rk;
        logic [3:0]   typ;
        logic         rw;
        logic         rdsrc;
        logic [255:0] pl;
    } ent_t;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, stall = 1'b0;
    logic v0 = 1'b0, v1 = 1'b0;
    ent_t s0 = '0, s1 = '0;
    ent_t z = '0;

    logic         in_ready, ov0, ov1, osw, orw0, orw1;
    logic [4:0]   ord0, orj0, ork0, ord1, orj1, ork1;
    logic [3:0]   otyp0, otyp1;
    logic [255:0] opl0, opl1;

    int errors = 0;
    int checks = 0;
    int seq = 1;

    always #5 clk = ~clk;

    dual_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(256), .MC_LAT(MCL)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .stall_i(stall),
        .in_valid0_i(v0), .in_valid1_i(v1), .in_ready_o(in_ready),
        .in_rd0_i(s0.rd), .in_rj0_i(s0.rj), .in_rk0_i(s0.rk), .in_type0_i(s0.typ),
        .in_regwrite0_i(s0.rw), .in_rdsrc0_i(s0.rdsrc), .in_payload0_i(s0.pl),
        .in_rd1_i(s1.rd), .in_rj1_i(s1.rj), .in_rk1_i(s1.rk), .in_type1_i(s1.typ),
        .in_regwrite1_i(s1.rw), .in_rdsrc1_i(s1.rdsrc), .in_payload1_i(s1.pl),
        .out_valid0_o(ov0), .out_rd0_o(ord0), .out_rj0_o(orj0), .out_rk0_o(ork0),
        .out_type0_o(otyp0), .out_regwrite0_o(orw0), .out_payload0_o(opl0),
        .out_valid1_o(ov1), .out_rd1_o(ord1), .out_rj1_o(orj1), .out_rk1_o(ork1),
        .out_type1_o(otyp1), .out_regwrite1_o(orw1), .out_payload1_o(opl1),
        .out_swap_o(osw)
    );

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    ent_t mq[$];
    int   rt[32];      // last decision tick at which register r is still busy
    int   tick = 0;    // count of non-stalled issue decisions
    logic ev0, ev1, esw;
    ent_t e0, e1;

    function automatic logic busy(input logic [4:0] r);
        return (r != 5'd0) && (tick <= rt[r]);
    endfunction

    function automatic logic src_busy(input ent_t e);
        return busy(e.rj) || busy(e.rk) || (e.rdsrc && busy(e.rd));
    endfunction

    function automatic logic reads(input ent_t e, input logic [4:0] r);
        return (r != 5'd0) && (e.rj == r || e.rk == r || (e.rdsrc && e.rd == r));
    endfunction

    function automatic logic mc(input ent_t e);
        return e.rw && e.rd != 5'd0 && (e.typ inside {4'd2, 4'd3, 4'd4, 4'd5});
    endfunction

    function automatic logic p0(input logic [3:0] t);
        return t inside {4'd0, 4'd1, 4'd4, 4'd7, 4'd8, 4'd9};
    endfunction

    function automatic logic [275:0] strip(input ent_t e);
        return {e.rd, e.rj, e.rk, e.typ, e.rw, e.pl};
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int r = 0; r < 32; r++) rt[r] = -1;
        ev0 = 1'b0; ev1 = 1'b0; esw = 1'b0; e0 = '0; e1 = '0;
    endtask

    task automatic model_step();
        int   sz;
        logic rdy, hok, pair, swp;
        ent_t h, n;
        sz = mq.size();
        rdy = (sz <= DEPTH - 2);
        hok = 1'b0; pair = 1'b0; swp = 1'b0; h = '0; n = '0;
        if (flush) begin
            model_reset();
            return;
        end
        if (!stall) begin
            if (sz >= 1) begin
                h = mq[0];
                hok = !src_busy(h);
            end
            if (hok && sz >= 2) begin
                n = mq[1];
                if (!src_busy(n) && !(h.rw && reads(n, h.rd)) &&
                    !(h.rw && n.rw && h.rd == n.rd && h.rd != 5'd0)) begin
                    if (p0(n.typ)) pair = 1'b1;
`ifdef DISPATCH_SWAP_EN
                    else if (p0(h.typ) && !(n.typ inside {4'd3, 4'd6, 4'd10})) swp = 1'b1;
`endif
                end
            end
            ev1 = hok;
            ev0 = pair | swp;
            esw = swp;
            e1  = !hok ? '0 : (swp ? n : h);
            e0  = swp ? h : (pair ? n : '0);
            if (hok && mc(h)) rt[h.rd] = tick + MCL;
            if ((pair || swp) && mc(n)) rt[n.rd] = tick + MCL;
            if (hok) void'(mq.pop_front());
            if (pair || swp) void'(mq.pop_front());
            tick++;
        end
        if (rdy) begin
            if (v0) mq.push_back(s0);
            if (v1) mq.push_back(s1);
        end
    endtask

    task automatic compare();
        chk("in_ready", CW'(in_ready), CW'(mq.size() <= DEPTH - 2));
        chk("valid0", CW'(ov0), CW'(ev0));
        chk("valid1", CW'(ov1), CW'(ev1));
        chk("swap", CW'(osw), CW'(esw));
        chk("pipe0", CW'({ord0, orj0, ork0, otyp0, orw0, opl0}), CW'(strip(e0)));
        chk("pipe1", CW'({ord1, orj1, ork1, otyp1, orw1, opl1}), CW'(strip(e1)));
    endtask

    // Model update on each edge, DUT comparison just after it
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step();
            #1;
            compare();
        end
    end

    // ---------------- stimulus ----------------
    function automatic ent_t mk(input int rd, input int rj, input int rk, input int typ);
        ent_t e;
        e.rd = 5'(rd); e.rj = 5'(rj); e.rk = 5'(rk); e.typ = 4'(typ);
        e.rw = 1'b1; e.rdsrc = 1'b0;
        e.pl = {8{32'(seq * 32'h9E37_79B9)}};
        seq++;
        return e;
    endfunction

    task automatic put(input logic a_v, input ent_t a, input logic b_v, input ent_t b);
        v0 = a_v; s0 = a; v1 = b_v; s1 = b;
    endtask

    task automatic idle();
        put(1'b0, z, 1'b0, z);
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_valid0", CW'(ov0), CW'(0));
        chk("reset_valid1", CW'(ov1), CW'(0));
        chk("reset_ready", CW'(in_ready), CW'(1));

        // Independent pair
        put(1'b1, mk(1, 2, 3, 0), 1'b1, mk(4, 5, 6, 0));
        @(negedge clk); idle();
        @(negedge clk);
        chk("pair_valid1", CW'(ov1), CW'(1));
        chk("pair_rd1", CW'(ord1), CW'(1));
        chk("pair_valid0", CW'(ov0), CW'(1));
        chk("pair_rd0", CW'(ord0), CW'(4));

        // RAW inside the pair
        put(1'b1, mk(1, 2, 0, 0), 1'b1, mk(5, 1, 0, 0));
        @(negedge clk); idle();
        @(negedge clk);
        chk("raw_first_rd1", CW'(ord1), CW'(1));
        chk("raw_first_valid0", CW'(ov0), CW'(0));
        @(negedge clk);
        chk("raw_second_valid1", CW'(ov1), CW'(1));
        chk("raw_second_rd1", CW'(ord1), CW'(5));

        // Multi-cycle writer blocks its reader for MC_LAT decisions
        put(1'b1, mk(7, 2, 3, 4), 1'b1, mk(8, 7, 0, 0));
        @(negedge clk); idle();
        @(negedge clk);
        chk("mc_mul_rd1", CW'(ord1), CW'(7));
        chk("mc_mul_valid0", CW'(ov0), CW'(0));
        for (int i = 0; i < MCL; i++) begin
            @(negedge clk);
            chk("mc_blocked_valid1", CW'(ov1), CW'(0));
        end
        @(negedge clk);
        chk("mc_add_valid1", CW'(ov1), CW'(1));
        chk("mc_add_rd1", CW'(ord1), CW'(8));

        // mul writing r0 never blocks readers of r0; lone slot-1 compacted
        put(1'b1, mk(0, 2, 3, 4), 1'b1, mk(9, 0, 0, 0));
        @(negedge clk); put(1'b0, z, 1'b1, mk(10, 0, 0, 0));
        @(negedge clk); idle();
        chk("r0_valid0", CW'(ov0), CW'(1));
        chk("r0_rd0", CW'(ord0), CW'(9));
        @(negedge clk);
        chk("r0_next_rd1", CW'(ord1), CW'(10));
        chk("r0_next_valid1", CW'(ov1), CW'(1));

        // Stall holds the issue registers
        @(negedge clk);
        put(1'b1, mk(1, 20, 21, 0), 1'b1, mk(2, 22, 23, 0));
        @(negedge clk); put(1'b1, mk(3, 24, 25, 0), 1'b1, mk(4, 26, 27, 0));
        @(negedge clk); idle(); stall = 1'b1;
        chk("stall_pre_rd1", CW'(ord1), CW'(1));
        @(negedge clk);
        chk("stall_hold_rd1", CW'(ord1), CW'(1));
        chk("stall_hold_rd0", CW'(ord0), CW'(2));
        @(negedge clk); stall = 1'b0;
        @(negedge clk);
        chk("unstall_rd1", CW'(ord1), CW'(3));
        chk("unstall_rd0", CW'(ord0), CW'(4));

        // Fill under stall, drain across the pointer wrap, flush mid-drain
        @(negedge clk); stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, mk(11 + 2 * i, 0, 0, 0), 1'b1, mk(12 + 2 * i, 0, 0, 0));
            @(negedge clk);
        end
        chk("full_ready", CW'(in_ready), CW'(0));
        put(1'b1, mk(30, 0, 0, 0), 1'b1, mk(31, 0, 0, 0));
        @(negedge clk); idle(); stall = 1'b0;
        chk("full_ready_hold", CW'(in_ready), CW'(0));
        @(negedge clk);
        chk("drain1_rd1", CW'(ord1), CW'(11));
        chk("drain1_rd0", CW'(ord0), CW'(12));
        @(negedge clk);
        chk("drain2_rd1", CW'(ord1), CW'(13));
        chk("drain2_rd0", CW'(ord0), CW'(14));
        flush = 1'b1;
        put(1'b1, mk(25, 0, 0, 0), 1'b1, mk(26, 0, 0, 0));
        @(negedge clk); flush = 1'b0; idle();
        chk("flush_valid1", CW'(ov1), CW'(0));
        chk("flush_valid0", CW'(ov0), CW'(0));
        chk("flush_ready", CW'(in_ready), CW'(1));
        @(negedge clk);
        chk("flush_empty", CW'(ov1), CW'(0));

        // alu followed by load
        put(1'b1, mk(1, 2, 3, 0), 1'b1, mk(2, 4, 0, 5));
        @(negedge clk); idle();
        @(negedge clk);
`ifdef DISPATCH_SWAP_EN
        chk("swap_flag", CW'(osw), CW'(1));
        chk("swap_rd0", CW'(ord0), CW'(1));
        chk("swap_rd1", CW'(ord1), CW'(2));
        chk("swap_type1", CW'(otyp1), CW'(5));
        @(negedge clk);
`else
        chk("noswap_flag", CW'(osw), CW'(0));
        chk("noswap_rd1", CW'(ord1), CW'(1));
        chk("noswap_valid0", CW'(ov0), CW'(0));
        @(negedge clk);
        chk("noswap_ld_rd1", CW'(ord1), CW'(2));
        chk("noswap_ld_type1", CW'(otyp1), CW'(5));
`endif

        // Asynchronous reset with three entries queued
        @(negedge clk);
        put(1'b1, mk(1, 3, 4, 0), 1'b1, mk(5, 6, 0, 0));
        @(negedge clk); put(1'b1, mk(6, 0, 0, 0), 1'b1, mk(8, 0, 0, 0));
        @(negedge clk); put(1'b1, mk(9, 0, 0, 0), 1'b0, z); stall = 1'b1;
        @(negedge clk); idle();
        chk("prereset_valid1", CW'(ov1), CW'(1));
        chk("prereset_ready", CW'(in_ready), CW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid0", CW'(ov0), CW'(0));
        chk("async_rst_valid1", CW'(ov1), CW'(0));
        chk("async_rst_ready", CW'(in_ready), CW'(1));
        @(negedge clk); rst_n = 1'b1; stall = 1'b0;
        @(negedge clk);
        chk("postrst_valid1", CW'(ov1), CW'(0));
        chk("postrst_valid0", CW'(ov0), CW'(0));
        @(negedge clk);
        chk("postrst_empty", CW'(ov1), CW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
